// File: rtl/cv32e40p_wb_pkg.sv
// -----------------------------------------------------------------------------
// cv32e40p_wb_pkg
// Shared types for the write-back arbiter and its LSU response FIFO.
//   WB_ADDR_WIDTH / WB_DATA_WIDTH : field widths of a queued register write
//   wb_req_t                      : one register write {addr, data}
//   wb_src_e                      : which source drives write port B this cycle
// -----------------------------------------------------------------------------
package cv32e40p_wb_pkg;

    localparam int unsigned WB_ADDR_WIDTH = 6;
    localparam int unsigned WB_DATA_WIDTH = 32;

    typedef struct packed {
        logic [WB_ADDR_WIDTH-1:0] addr;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        WB_SRC_NONE,
        WB_SRC_FIFO,
        WB_SRC_LSU,
        WB_SRC_MDU
    } wb_src_e;

endpackage

// File: rtl/cv32e40p_wb_fifo.sv
// -----------------------------------------------------------------------------
// cv32e40p_wb_fifo
// Synchronous FIFO of wb_req_t holding LSU load responses while write-back
// is held or port B is busy draining older entries.
//   clk, rst      : clock, synchronous active-high reset (empties the FIFO)
//   push/push_req : write one entry (caller guarantees !full)
//   pop           : drop the head entry (caller guarantees !empty)
//   full, empty   : occupancy flags; full at count == DEPTH
//   head          : oldest entry
//   entry_valid   : per-slot occupancy, indexed by physical slot
//   entry_addr    : per-slot destination address, for hazard/pending logic
// -----------------------------------------------------------------------------
module cv32e40p_wb_fifo
    import cv32e40p_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  push,
    input  wb_req_t                               push_req,
    input  logic                                  pop,
    output logic                                  full,
    output logic                                  empty,
    output wb_req_t                               head,
    output logic [DEPTH-1:0]                      entry_valid,
    output logic [DEPTH-1:0][WB_ADDR_WIDTH-1:0]   entry_addr
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    wb_req_t            mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: ;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; occupancy is tracked
    // by count/pointers, so stale slot contents are never observed as valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_req;
    end

    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // A slot is live when its distance from the read pointer (mod DEPTH)
    // is below the current count.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_valid[i] = {1'b0, PTR_W'(PTR_W'(i) - rd_ptr)} < count;
            entry_addr[i]  = mem[i].addr;
        end
    end

endmodule

// File: rtl/cv32e40p_wb_arbiter.sv
// -----------------------------------------------------------------------------
// cv32e40p_wb_arbiter
// Write-back arbiter in front of the register file.
//   Port A : ALU results.
//   Port B : LSU load data (queued FIFO first, else bypass) then MDU results.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   hold_i                   : freeze write-back (no writes, no pops)
//   alu_* / lsu_* / mdu_*    : valid/ready result channels with addr/data
//   waddr_a_o/wdata_a_o/we_a_o : registered register-file write port A
//   waddr_b_o/wdata_b_o/we_b_o : registered register-file write port B
//   pending_o                : per-register "write queued or in flight"
// ADDR_WIDTH/DATA_WIDTH must match the widths of wb_req_t in the package.
// -----------------------------------------------------------------------------
module cv32e40p_wb_arbiter
    import cv32e40p_wb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = WB_DATA_WIDTH,
    parameter int unsigned LSU_DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     hold_i,
    input  logic                     alu_valid_i,
    output logic                     alu_ready_o,
    input  logic [ADDR_WIDTH-1:0]    alu_waddr_i,
    input  logic [DATA_WIDTH-1:0]    alu_wdata_i,
    input  logic                     lsu_valid_i,
    output logic                     lsu_ready_o,
    input  logic [ADDR_WIDTH-1:0]    lsu_waddr_i,
    input  logic [DATA_WIDTH-1:0]    lsu_wdata_i,
    input  logic                     mdu_valid_i,
    output logic                     mdu_ready_o,
    input  logic [ADDR_WIDTH-1:0]    mdu_waddr_i,
    input  logic [DATA_WIDTH-1:0]    mdu_wdata_i,
    output logic [ADDR_WIDTH-1:0]    waddr_a_o,
    output logic [DATA_WIDTH-1:0]    wdata_a_o,
    output logic                     we_a_o,
    output logic [ADDR_WIDTH-1:0]    waddr_b_o,
    output logic [DATA_WIDTH-1:0]    wdata_b_o,
    output logic                     we_b_o,
    output logic [2**ADDR_WIDTH-1:0] pending_o
);

    logic                                    fifo_full;
    logic                                    fifo_empty;
    wb_req_t                                 fifo_head;
    logic [LSU_DEPTH-1:0]                    entry_valid;
    logic [LSU_DEPTH-1:0][WB_ADDR_WIDTH-1:0] entry_addr;
    logic                                    fifo_push;
    logic                                    fifo_pop;
    wb_req_t                                 lsu_req;

    wb_src_e  src;
    wb_req_t  sel_req;
    logic     lsu_fire;
    logic     alu_fire;
    logic     hazard;

    assign lsu_req.addr = lsu_waddr_i;
    assign lsu_req.data = lsu_wdata_i;

    // Port-B source select. Queued loads drain before a new load may bypass,
    // which keeps load write-back in acceptance order.
    // NOTE: every combinational output gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        src     = WB_SRC_NONE;
        sel_req = '0;
        if (!rst && !hold_i) begin
            if (!fifo_empty) begin
                src     = WB_SRC_FIFO;
                sel_req = fifo_head;
            end else if (lsu_valid_i) begin
                src     = WB_SRC_LSU;
                sel_req = lsu_req;
            end else if (mdu_valid_i) begin
                src          = WB_SRC_MDU;
                sel_req.addr = mdu_waddr_i;
                sel_req.data = mdu_wdata_i;
            end
        end
    end

    // Bypass only happens with the FIFO empty, hence never full: an LSU
    // request selected for bypass is always also accepted.
    assign lsu_ready_o = !rst && !fifo_full;
    assign mdu_ready_o = !rst && !hold_i && fifo_empty && !lsu_valid_i;
    assign lsu_fire    = lsu_valid_i && lsu_ready_o;
    assign fifo_push   = lsu_fire && (src != WB_SRC_LSU);
    assign fifo_pop    = (src == WB_SRC_FIFO);

    // ALU must wait while an older port-B write to the same register is
    // queued or being launched, otherwise the older value would land last.
    always_comb begin
        hazard = 1'b0;
        if (alu_waddr_i != '0) begin
            for (int i = 0; i < LSU_DEPTH; i++) begin
                if (entry_valid[i] && entry_addr[i] == alu_waddr_i) hazard = 1'b1;
            end
            if (lsu_fire && lsu_waddr_i == alu_waddr_i)             hazard = 1'b1;
            if (src != WB_SRC_NONE && sel_req.addr == alu_waddr_i)  hazard = 1'b1;
        end
    end

    assign alu_ready_o = !rst && !hold_i && !hazard;
    assign alu_fire    = alu_valid_i && alu_ready_o;

    cv32e40p_wb_fifo #(
        .DEPTH (LSU_DEPTH)
    ) u_lsu_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (fifo_push),
        .push_req    (lsu_req),
        .pop         (fifo_pop),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .head        (fifo_head),
        .entry_valid (entry_valid),
        .entry_addr  (entry_addr)
    );

    // Write enables pulse for one cycle; x0 writes are accepted but dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_a_o    <= 1'b0;
            waddr_a_o <= '0;
            wdata_a_o <= '0;
        end else begin
            we_a_o <= alu_fire && (alu_waddr_i != '0);
            if (alu_fire) begin
                waddr_a_o <= alu_waddr_i;
                wdata_a_o <= alu_wdata_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_b_o    <= 1'b0;
            waddr_b_o <= '0;
            wdata_b_o <= '0;
        end else begin
            we_b_o <= (src != WB_SRC_NONE) && (sel_req.addr != '0);
            if (src != WB_SRC_NONE) begin
                waddr_b_o <= sel_req.addr;
                wdata_b_o <= sel_req.data;
            end
        end
    end

    always_comb begin
        pending_o = '0;
        for (int i = 0; i < LSU_DEPTH; i++) begin
            if (entry_valid[i]) pending_o[entry_addr[i]] = 1'b1;
        end
        if (we_a_o) pending_o[waddr_a_o] = 1'b1;
        if (we_b_o) pending_o[waddr_b_o] = 1'b1;
        pending_o[0] = 1'b0;
    end

endmodule

// File: tb/tb_cv32e40p_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cv32e40p_wb_arbiter
// Directed stimulus for the write-back arbiter. Accepted writes are queued
// as expected port-A / port-B writes; a negedge monitor pops and compares
// whenever a write enable is high. Directed checks cover readiness, pending
// vector, hold, hazards, x0 and reset behaviour.
// -----------------------------------------------------------------------------
module tb_cv32e40p_wb_arbiter;

    localparam int AW = 6;
    localparam int DW = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           hold_i;
    logic           alu_valid_i, alu_ready_o;
    logic [AW-1:0]  alu_waddr_i;
    logic [DW-1:0]  alu_wdata_i;
    logic           lsu_valid_i, lsu_ready_o;
    logic [AW-1:0]  lsu_waddr_i;
    logic [DW-1:0]  lsu_wdata_i;
    logic           mdu_valid_i, mdu_ready_o;
    logic [AW-1:0]  mdu_waddr_i;
    logic [DW-1:0]  mdu_wdata_i;
    logic [AW-1:0]  waddr_a_o, waddr_b_o;
    logic [DW-1:0]  wdata_a_o, wdata_b_o;
    logic           we_a_o, we_b_o;
    logic [63:0]    pending_o;

    cv32e40p_wb_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LSU_DEPTH  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .hold_i      (hold_i),
        .alu_valid_i (alu_valid_i),
        .alu_ready_o (alu_ready_o),
        .alu_waddr_i (alu_waddr_i),
        .alu_wdata_i (alu_wdata_i),
        .lsu_valid_i (lsu_valid_i),
        .lsu_ready_o (lsu_ready_o),
        .lsu_waddr_i (lsu_waddr_i),
        .lsu_wdata_i (lsu_wdata_i),
        .mdu_valid_i (mdu_valid_i),
        .mdu_ready_o (mdu_ready_o),
        .mdu_waddr_i (mdu_waddr_i),
        .mdu_wdata_i (mdu_wdata_i),
        .waddr_a_o   (waddr_a_o),
        .wdata_a_o   (wdata_a_o),
        .we_a_o      (we_a_o),
        .waddr_b_o   (waddr_b_o),
        .wdata_b_o   (wdata_b_o),
        .we_b_o      (we_b_o),
        .pending_o   (pending_o)
    );

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          cyc;   // cycle the write must appear in; -1 = order only
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   lsu_lat_chk;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every presented write must match the oldest
    // expected write for that port.
    always @(negedge clk) begin
        exp_t e;
        if (we_a_o === 1'b1) begin
            if (qa.size() == 0) begin
                check("port_a_spurious_we", 64'(we_a_o), 64'd0);
            end else begin
                e = qa.pop_front();
                check("port_a_addr", 64'(waddr_a_o), 64'(e.addr));
                check("port_a_data", 64'(wdata_a_o), 64'(e.data));
                if (e.cyc >= 0) check("port_a_latency", 64'(cyc), 64'(e.cyc));
            end
        end
        if (we_b_o === 1'b1) begin
            if (qb.size() == 0) begin
                check("port_b_spurious_we", 64'(we_b_o), 64'd0);
            end else begin
                e = qb.pop_front();
                check("port_b_addr", 64'(waddr_b_o), 64'(e.addr));
                check("port_b_data", 64'(wdata_b_o), 64'(e.data));
                if (e.cyc >= 0) check("port_b_latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic set_idle();
        alu_valid_i = 1'b0; alu_waddr_i = '0; alu_wdata_i = '0;
        lsu_valid_i = 1'b0; lsu_waddr_i = '0; lsu_wdata_i = '0;
        mdu_valid_i = 1'b0; mdu_waddr_i = '0; mdu_wdata_i = '0;
    endtask

    // One clock edge. Handshakes seen just before the edge become expected
    // writes one cycle later; a reset edge discards everything expected.
    task automatic step();
        @(negedge clk);
        if (alu_valid_i && alu_ready_o && alu_waddr_i != '0)
            qa.push_back('{int'(alu_waddr_i), alu_wdata_i, cyc + 1});
        if (lsu_valid_i && lsu_ready_o && lsu_waddr_i != '0)
            qb.push_back('{int'(lsu_waddr_i), lsu_wdata_i, lsu_lat_chk ? cyc + 1 : -1});
        if (mdu_valid_i && mdu_ready_o && mdu_waddr_i != '0)
            qb.push_back('{int'(mdu_waddr_i), mdu_wdata_i, cyc + 1});
        @(posedge clk);
        if (rst) begin
            qa.delete();
            qb.delete();
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; hold_i = 1'b0; lsu_lat_chk = 1'b1;
        set_idle();

        // ---------------- reset state ----------------
        alu_valid_i = 1'b1; alu_waddr_i = 6'd9; alu_wdata_i = 32'h9;
        step(); step();
        check("rst_we_a",      64'(we_a_o),      64'd0);
        check("rst_we_b",      64'(we_b_o),      64'd0);
        check("rst_waddr_a",   64'(waddr_a_o),   64'd0);
        check("rst_wdata_a",   64'(wdata_a_o),   64'd0);
        check("rst_waddr_b",   64'(waddr_b_o),   64'd0);
        check("rst_wdata_b",   64'(wdata_b_o),   64'd0);
        check("rst_pending",   pending_o,        64'd0);
        check("rst_alu_ready", 64'(alu_ready_o), 64'd0);
        check("rst_lsu_ready", 64'(lsu_ready_o), 64'd0);
        check("rst_mdu_ready", 64'(mdu_ready_o), 64'd0);
        alu_valid_i = 1'b0;
        rst = 1'b0; #1;
        check("post_rst_lsu_ready", 64'(lsu_ready_o), 64'd1);
        check("post_rst_mdu_ready", 64'(mdu_ready_o), 64'd1);
        check("post_rst_alu_ready", 64'(alu_ready_o), 64'd1);
        step();

        // ---------------- ALU only ----------------
        alu_valid_i = 1'b1; alu_waddr_i = 6'd5; alu_wdata_i = 32'hDEADBEEF; #1;
        check("alu_ready", 64'(alu_ready_o), 64'd1);
        step();
        alu_valid_i = 1'b0; #1;
        check("alu_we_a",    64'(we_a_o),    64'd1);
        check("alu_waddr_a", 64'(waddr_a_o), 64'd5);
        check("alu_wdata_a", 64'(wdata_a_o), 64'hDEADBEEF);
        check("alu_pending", pending_o,      64'h20);
        step();
        check("alu_we_a_drop",    64'(we_a_o), 64'd0);
        check("alu_pending_drop", pending_o,   64'd0);

        // ---------------- LSU vs MDU ----------------
        lsu_valid_i = 1'b1; lsu_waddr_i = 6'd3; lsu_wdata_i = 32'h11;
        mdu_valid_i = 1'b1; mdu_waddr_i = 6'd4; mdu_wdata_i = 32'h22; #1;
        check("lvm_mdu_ready_blocked", 64'(mdu_ready_o), 64'd0);
        check("lvm_lsu_ready",         64'(lsu_ready_o), 64'd1);
        step();
        lsu_valid_i = 1'b0; #1;
        check("lvm_mdu_ready_next", 64'(mdu_ready_o), 64'd1);
        check("lvm_we_b_lsu",       64'(we_b_o),      64'd1);
        check("lvm_waddr_b_lsu",    64'(waddr_b_o),   64'd3);
        check("lvm_pending_lsu",    pending_o,        64'h8);
        step();
        mdu_valid_i = 1'b0; #1;
        check("lvm_we_b_mdu",    64'(we_b_o),    64'd1);
        check("lvm_waddr_b_mdu", 64'(waddr_b_o), 64'd4);
        step(); step();

        // ---------------- hold fill ----------------
        hold_i = 1'b1; lsu_lat_chk = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            lsu_valid_i = 1'b1; lsu_waddr_i = 6'(i); lsu_wdata_i = 32'h100 + 32'(i); #1;
            check("hold_lsu_ready", 64'(lsu_ready_o), (i <= 4) ? 64'd1 : 64'd0);
            check("hold_no_we_b",   64'(we_b_o),      64'd0);
            step();
        end
        lsu_valid_i = 1'b0;
        alu_valid_i = 1'b1; alu_waddr_i = 6'd9; alu_wdata_i = 32'h5A; #1;
        check("hold_pending",   pending_o,        64'h1E);
        check("hold_alu_stall", 64'(alu_ready_o), 64'd0);
        check("hold_no_we_b2",  64'(we_b_o),      64'd0);
        alu_valid_i = 1'b0;
        step();
        check("hold_no_we_b3", 64'(we_b_o), 64'd0);
        hold_i = 1'b0; #1;
        check("release_full_lsu_ready", 64'(lsu_ready_o), 64'd0);
        for (int k = 1; k <= 4; k++) begin
            step();
            check("release_we_b",    64'(we_b_o),    64'd1);
            check("release_waddr_b", 64'(waddr_b_o), 64'(k));
        end
        lsu_lat_chk = 1'b1;
        lsu_valid_i = 1'b1; lsu_waddr_i = 6'd5; lsu_wdata_i = 32'h105; #1;
        check("bypass_lsu_ready", 64'(lsu_ready_o), 64'd1);
        step();
        lsu_valid_i = 1'b0; #1;
        check("bypass_we_b",    64'(we_b_o),    64'd1);
        check("bypass_waddr_b", 64'(waddr_b_o), 64'd5);
        step(); step();

        // ---------------- hazard vs FIFO entry ----------------
        hold_i = 1'b1; lsu_lat_chk = 1'b0;
        lsu_valid_i = 1'b1; lsu_waddr_i = 6'd7; lsu_wdata_i = 32'h77;
        step();
        lsu_valid_i = 1'b0;
        alu_valid_i = 1'b1; alu_waddr_i = 6'd7; alu_wdata_i = 32'hA7;
        hold_i = 1'b0; #1;
        check("haz_alu_blocked", 64'(alu_ready_o), 64'd0);
        step();
        check("haz_we_b",      64'(we_b_o),      64'd1);
        check("haz_waddr_b",   64'(waddr_b_o),   64'd7);
        check("haz_we_a_idle", 64'(we_a_o),      64'd0);
        check("haz_alu_free",  64'(alu_ready_o), 64'd1);
        step();
        alu_valid_i = 1'b0; #1;
        check("haz_we_a",    64'(we_a_o),    64'd1);
        check("haz_waddr_a", 64'(waddr_a_o), 64'd7);
        check("haz_we_b_off", 64'(we_b_o),   64'd0);
        step();
        lsu_lat_chk = 1'b1;

        // ---------------- hazard vs selected MDU ----------------
        mdu_valid_i = 1'b1; mdu_waddr_i = 6'd9; mdu_wdata_i = 32'h99;
        alu_valid_i = 1'b1; alu_waddr_i = 6'd9; alu_wdata_i = 32'hA9; #1;
        check("mhaz_alu_blocked", 64'(alu_ready_o), 64'd0);
        check("mhaz_mdu_ready",   64'(mdu_ready_o), 64'd1);
        step();
        mdu_valid_i = 1'b0; #1;
        check("mhaz_alu_free", 64'(alu_ready_o), 64'd1);
        step();
        alu_valid_i = 1'b0; #1;
        check("mhaz_waddr_a", 64'(waddr_a_o), 64'd9);
        step();

        // ---------------- x0 ----------------
        alu_valid_i = 1'b1; alu_waddr_i = 6'd0; alu_wdata_i = 32'h1234; #1;
        check("x0_alu_ready", 64'(alu_ready_o), 64'd1);
        step();
        alu_valid_i = 1'b0; #1;
        check("x0_we_a",    64'(we_a_o), 64'd0);
        check("x0_pending", pending_o,   64'd0);
        step();

        // ---------------- reset mid-operation ----------------
        hold_i = 1'b1; lsu_lat_chk = 1'b0;
        for (int i = 11; i <= 13; i++) begin
            lsu_valid_i = 1'b1; lsu_waddr_i = 6'(i); lsu_wdata_i = 32'h200 + 32'(i);
            step();
        end
        lsu_valid_i = 1'b0; #1;
        check("mrst_pending_before", pending_o, 64'h3800);
        rst = 1'b1; hold_i = 1'b0; #1;
        check("mrst_lsu_ready_in_rst", 64'(lsu_ready_o), 64'd0);
        step();
        rst = 1'b0; #1;
        check("mrst_we_a",      64'(we_a_o),      64'd0);
        check("mrst_we_b",      64'(we_b_o),      64'd0);
        check("mrst_pending",   pending_o,        64'd0);
        check("mrst_lsu_ready", 64'(lsu_ready_o), 64'd1);
        step();
        check("mrst_no_write_b", 64'(we_b_o), 64'd0);
        check("mrst_pending2",   pending_o,   64'd0);
        lsu_lat_chk = 1'b1;
        lsu_valid_i = 1'b1; lsu_waddr_i = 6'd2; lsu_wdata_i = 32'h2222;
        step();
        lsu_valid_i = 1'b0; #1;
        check("mrst_after_waddr_b", 64'(waddr_b_o), 64'd2);
        step(); step(); step();

        check("scoreboard_a_drained", 64'(qa.size()), 64'd0);
        check("scoreboard_b_drained", 64'(qb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
